// File: rtl/icache_refill.sv
// Instruction cache refill engine: fetches one 32-bit word as four byte reads
// from the memory arbiter, assembles it little-endian and writes it into the
// instruction cache with a single-cycle fill strobe.
module icache_refill #(
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        miss_valid,
  input  logic [31:0] miss_addr,
  input  logic        flush,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_grant,
  input  logic [7:0]  mem_data,
  output logic        fill_we,
  output logic [31:0] fill_addr,
  output logic [31:0] fill_data
);

  localparam logic [2:0] LastCnt = 3'(WORD_BYTES);

  typedef enum logic [1:0] {StIdle, StFetch, StDone} state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  issue_q, issue_d;
  logic [2:0]  recv_q, recv_d;
  logic        inflight_q, inflight_d;
  logic [31:0] word_q, word_d;
  logic [31:0] fill_addr_q, fill_addr_d;
  logic [31:0] fill_data_q, fill_data_d;
  logic        grant_fire;

  // Byte-offset bits of the miss address are deliberately dropped.
  logic unused_lsbs;
  assign unused_lsbs = ^miss_addr[1:0];

  // State register: synchronous reset clears everything, including the partial word.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      base_q      <= '0;
      issue_q     <= '0;
      recv_q      <= '0;
      inflight_q  <= 1'b0;
      word_q      <= '0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_q     <= issue_d;
      recv_q      <= recv_d;
      inflight_q  <= inflight_d;
      word_q      <= word_d;
      fill_addr_q <= fill_addr_d;
      fill_data_q <= fill_data_d;
    end
  end

  // Next-state logic: byte capture, request issue, FSM transitions, flush override.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_d     = issue_q;
    recv_d      = recv_q;
    word_d      = word_q;
    fill_addr_d = fill_addr_q;
    fill_data_d = fill_data_q;
    grant_fire  = mem_req & mem_grant;
    inflight_d  = grant_fire;

    // A byte already in flight lands even while stalled by rdy_in.
    if (inflight_q) begin
      word_d[{recv_q[1:0], 3'b000} +: 8] = mem_data;
      recv_d = recv_q + 3'd1;
    end
    if (grant_fire) begin
      issue_d = issue_q + 3'd1;
    end

    if (rdy_in) begin
      unique case (state_q)
        StIdle: begin
          if (miss_valid) begin
            state_d = StFetch;
            base_d  = {miss_addr[31:2], 2'b00};
            issue_d = '0;
            recv_d  = '0;
          end
        end
        StFetch: begin
          if (recv_d == LastCnt) begin
            state_d     = StDone;
            fill_addr_d = base_q;
            fill_data_d = word_d;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    // Flush wins over a simultaneous miss and drops any byte still returning.
    if (flush) begin
      state_d    = StIdle;
      issue_d    = '0;
      recv_d     = '0;
      inflight_d = 1'b0;
    end
  end

  // Outputs: requests and fill strobe are gated by rdy_in; fill data holds outside DONE.
  always_comb begin
    busy      = (state_q != StIdle);
    mem_req   = rdy_in && (state_q == StFetch) && (issue_q < LastCnt);
    mem_addr  = (state_q == StFetch) ? base_q + {29'b0, issue_q} : base_q;
    fill_we   = rdy_in && !flush && (state_q == StDone);
    fill_addr = fill_addr_q;
    fill_data = fill_data_q;
  end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill with a byte-memory model and a fill scoreboard.
module tb_icache_refill;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, miss_valid, flush, mem_grant;
  logic [31:0] miss_addr;
  logic        busy, mem_req, fill_we;
  logic [31:0] mem_addr, fill_addr, fill_data;
  logic [7:0]  mem_data = 8'hEE;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errs    = 0;
  int   t       = 0;

  always #5 clk_in = ~clk_in;

  icache_refill #(.WORD_BYTES(4)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .miss_valid (miss_valid),
    .miss_addr  (miss_addr),
    .flush      (flush),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_grant  (mem_grant),
    .mem_data   (mem_data),
    .fill_we    (fill_we),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data)
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h1000: return 8'h13;
      32'h1001: return 8'h00;
      32'h1002: return 8'h00;
      32'h1003: return 8'h93;
      32'h2000: return 8'h37;
      32'h2001: return 8'h05;
      32'h2002: return 8'h00;
      32'h2003: return 8'h00;
      default:  return 8'hEE;
    endcase
  endfunction

  // Memory returns the byte one cycle after each accepted request; junk otherwise.
  always @(posedge clk_in) begin
    mem_data <= (mem_req && mem_grant) ? mem_byte(mem_addr) : 8'hEE;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Mid-cycle sample point; any fill strobe is matched against the scoreboard.
  task automatic half();
    exp_t e;
    @(negedge clk_in);
    if (fill_we !== 1'b0) begin
      if (sb.size() == 0) begin
        chk("spurious_fill_we", {31'b0, fill_we}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("fill_addr", fill_addr, e.addr);
        chk("fill_data", fill_data, e.data);
        chk("fill_cycle", t, e.due);
      end
    end
  endtask

  task automatic next();
    @(posedge clk_in);
    #1;
    t++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      half();
      next();
    end
  endtask

  task automatic drain(input string tag);
    chk(tag, 32'(sb.size()), 32'h0);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; miss_valid = 1'b0; flush = 1'b0;
    mem_grant = 1'b0; miss_addr = '0;

    // Reset state
    #1;
    next();
    half();
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_fill_we", fill_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fill_addr", fill_addr, 0);
    chk("rst_fill_data", fill_data, 0);
    next();
    rst_in = 1'b0;
    run(2);

    // Basic refill, continuous grants: fill at T6
    t = 0; miss_valid = 1'b1; miss_addr = 32'h1002; mem_grant = 1'b1;
    sb.push_back('{32'h1000, 32'h9300_0013, 6});
    half();
    chk("basic_t0_mem_req", mem_req, 0);
    next();
    miss_valid = 1'b0; miss_addr = '0;
    for (int i = 0; i < 4; i++) begin
      half();
      chk("basic_mem_req", mem_req, 1);
      chk("basic_mem_addr", mem_addr, 32'h1000 + i);
      next();
    end
    half();
    chk("basic_t5_mem_req", mem_req, 0);
    chk("basic_t5_busy", busy, 1);
    next();
    run(1);
    half();
    chk("basic_t7_busy", busy, 0);
    chk("basic_hold_addr", fill_addr, 32'h1000);
    chk("basic_hold_data", fill_data, 32'h9300_0013);
    chk("basic_t7_mem_addr", mem_addr, 32'h1000);
    next();
    drain("basic_drain");

    // Grant stalls on T2, T3: fill at T8
    t = 0; miss_valid = 1'b1; miss_addr = 32'h1002; mem_grant = 1'b1;
    sb.push_back('{32'h1000, 32'h9300_0013, 8});
    run(1);
    miss_valid = 1'b0;
    run(1);
    mem_grant = 1'b0;
    for (int i = 0; i < 2; i++) begin
      half();
      chk("stall_mem_addr", mem_addr, 32'h1001);
      chk("stall_mem_req", mem_req, 1);
      next();
    end
    mem_grant = 1'b1;
    run(6);
    drain("stall_drain");

    // Flush on T3, new miss at T4 for 0x2000: fill at T10
    t = 0; miss_valid = 1'b1; miss_addr = 32'h1000;
    run(1);
    miss_valid = 1'b0;
    run(2);
    flush = 1'b1;
    run(1);
    flush = 1'b0;
    miss_valid = 1'b1; miss_addr = 32'h2000;
    sb.push_back('{32'h2000, 32'h0000_0537, 10});
    half();
    chk("flush_t4_busy", busy, 0);
    next();
    miss_valid = 1'b0;
    run(7);
    drain("flush_drain");

    // Flush and miss together in IDLE: stays idle
    flush = 1'b1; miss_valid = 1'b1; miss_addr = 32'h2000;
    run(1);
    flush = 1'b0; miss_valid = 1'b0;
    half();
    chk("flushmiss_busy", busy, 0);
    chk("flushmiss_mem_req", mem_req, 0);
    next();

    // rdy_in low on T2..T4: fill at T9
    t = 0; miss_valid = 1'b1; miss_addr = 32'h1000;
    sb.push_back('{32'h1000, 32'h9300_0013, 9});
    run(1);
    miss_valid = 1'b0;
    half();
    chk("rdy_t1_mem_req", mem_req, 1);
    next();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      half();
      chk("rdy_stall_mem_req", mem_req, 0);
      chk("rdy_stall_busy", busy, 1);
      next();
    end
    rdy_in = 1'b1;
    run(7);
    drain("rdy_drain");

    // Flush while in DONE suppresses the fill
    t = 0; miss_valid = 1'b1; miss_addr = 32'h2000;
    run(1);
    miss_valid = 1'b0;
    run(5);
    flush = 1'b1;
    half();
    chk("done_flush_busy", busy, 1);
    chk("done_flush_fill_we", fill_we, 0);
    next();
    flush = 1'b0;
    half();
    chk("done_flush_idle", busy, 0);
    next();

    // Reset on T3 mid-FETCH: all outputs zero at T4, then no fill
    t = 0; miss_valid = 1'b1; miss_addr = 32'h1000;
    run(1);
    miss_valid = 1'b0;
    run(2);
    rst_in = 1'b1;
    run(1);
    rst_in = 1'b0;
    half();
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_fill_we", fill_we, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_fill_addr", fill_addr, 0);
    chk("midrst_fill_data", fill_data, 0);
    next();
    run(10);
    drain("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
